// File: rtl/softex_tcdm_lane_sync_if.sv
// softex_tcdm_lane_sync_if: wide accelerator TCDM port plus the MP narrow cluster lanes it is split into
interface softex_tcdm_lane_sync_if #(
    parameter int unsigned DW = 128,
    parameter int unsigned MP = DW / 32
);
    logic                 in_req;
    logic                 in_gnt;
    logic [31:0]          in_add;
    logic                 in_wen;
    logic [DW/8-1:0]      in_be;
    logic [DW-1:0]        in_data;
    logic [DW-1:0]        in_r_data;
    logic                 in_r_valid;
    logic                 in_r_ready;
    logic [MP-1:0]        lane_req;
    logic [MP-1:0]        lane_gnt;
    logic [MP-1:0][31:0]  lane_add;
    logic [MP-1:0]        lane_wen;
    logic [MP-1:0][3:0]   lane_be;
    logic [MP-1:0][31:0]  lane_data;
    logic [MP-1:0][31:0]  lane_r_data;
    logic [MP-1:0]        lane_r_valid;
    modport slave (
        input  in_req, in_add, in_wen, in_be, in_data, in_r_ready, lane_gnt, lane_r_data, lane_r_valid,
        output in_gnt, in_r_data, in_r_valid, lane_req, lane_add, lane_wen, lane_be, lane_data
    );
    modport master (
        output in_req, in_add, in_wen, in_be, in_data, in_r_ready, lane_gnt, lane_r_data, lane_r_valid,
        input  in_gnt, in_r_data, in_r_valid, lane_req, lane_add, lane_wen, lane_be, lane_data
    );
endinterface

// File: rtl/softex_tcdm_lane_sync.sv
// softex_tcdm_lane_sync: joins per-lane grants/responses of MP TCDM lanes into one wide handshake.
// Optional watchdog on partially granted requests: define SOFTEX_LANE_SYNC_TIMEOUT_EN.
module softex_tcdm_lane_sync #(
    parameter int unsigned DW             = 128,
    parameter int unsigned MP             = DW / 32,
    parameter int unsigned RESP_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    softex_tcdm_lane_sync_if.slave    bus,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;

    if (DW % 32 != 0 || MP != DW / 32 || RESP_DEPTH == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("softex_tcdm_lane_sync: unsupported parameter set");
    end

    logic [MP-1:0]                        done_q;
    logic [CW-1:0]                        outstanding_q;
    logic [MP-1:0][RESP_DEPTH-1:0][31:0]  fifo_q;
    logic [MP-1:0][PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [MP-1:0][CW-1:0]                cnt_q;
    logic [MP-1:0]                        nonempty, push;
    logic                                 credit_ok, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_ok      = outstanding_q < CW'(RESP_DEPTH);
    assign bus.lane_req   = {MP{bus.in_req & credit_ok & ~clear_i}} & ~done_q;
    assign bus.in_gnt     = bus.in_req & credit_ok & ~clear_i & (&(done_q | bus.lane_gnt));
    assign bus.lane_wen   = {MP{bus.in_wen}};
    assign bus.in_r_valid = &nonempty;
    assign pop            = bus.in_r_valid & bus.in_r_ready & ~clear_i;
    assign push           = bus.lane_r_valid & {MP{~clear_i}};
    assign busy_o         = (outstanding_q != '0) | (|done_q);

    always_comb begin
        bus.lane_add  = '0;
        bus.lane_be   = '0;
        bus.lane_data = '0;
        bus.in_r_data = '0;
        nonempty      = '0;
        for (int k = 0; k < MP; k++) begin
            bus.lane_add[k]         = bus.in_add + 32'(4 * k);
            bus.lane_be[k]          = bus.in_be[4*k+:4];
            bus.lane_data[k]        = bus.in_data[32*k+:32];
            bus.in_r_data[32*k+:32] = fifo_q[k][rd_ptr_q[k]];
            nonempty[k]             = cnt_q[k] != '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q        <= '0;
            outstanding_q <= '0;
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            done_q        <= (clear_i | bus.in_gnt) ? '0 : done_q | (bus.lane_req & bus.lane_gnt);
            outstanding_q <= clear_i ? '0 : outstanding_q + CW'(bus.in_gnt) - CW'(pop);
            for (int k = 0; k < MP; k++) begin
                if (clear_i) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    cnt_q[k]    <= '0;
                end else begin
                    if (push[k]) begin
                        fifo_q[k][wr_ptr_q[k]] <= bus.lane_r_data[k];
                        wr_ptr_q[k]            <= nxt(wr_ptr_q[k]);
                    end
                    if (pop) rd_ptr_q[k] <= nxt(rd_ptr_q[k]);
                    cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(pop);
                end
            end
        end
    end

    // The credit limit bounds every lane FIFO; overflow means a lane answered without a request.
    for (genvar i = 0; i < MP; i++) begin : g_ovf
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(push[i] && cnt_q[i] == CW'(RESP_DEPTH) && !pop));
    end

`ifdef SOFTEX_LANE_SYNC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q, stalled;
    assign stalled = bus.in_req & (|done_q) & ~bus.in_gnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (clear_i | ~stalled) ? '0 : (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
            err_q <= ~clear_i & (err_q | (tmo_q == TW'(TIMEOUT_CYCLES)));
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule
